mips_dmem_mmio: RTL and testbench

Data-side memory subsystem for the single-cycle MIPS core. It consumes the core's `memwrite`/`memaddr`/`writedata` bus and returns `readdata` in the same cycle. It decodes each access to either a word-addressed data RAM or a memory-mapped I/O page. The I/O page holds a GPIO port, a free-running cycle counter and a programmable down-counting timer with a sticky expiry flag and an interrupt output.

---
 rtl/mips_dmem_mmio.sv | 135 +++++++++++++
 tb/tb_mips_dmem_mmio.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_mmio.sv
// Data-side memory for the single-cycle MIPS core: a word-addressed RAM plus an
// MMIO page holding GPIO, a free-running cycle counter and a down-counting timer.
module mips_dmem_mmio #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memwrite,
    input  logic [DATA_WIDTH-1:0] memaddr,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [DATA_WIDTH-1:0] ONE = 1;

    localparam logic [5:0] OFS_GPIO_OUT     = 6'h00;
    localparam logic [5:0] OFS_GPIO_IN      = 6'h01;
    localparam logic [5:0] OFS_CYCLE_CNT    = 6'h02;
    localparam logic [5:0] OFS_TIMER_LOAD   = 6'h03;
    localparam logic [5:0] OFS_TIMER_CTRL   = 6'h04;
    localparam logic [5:0] OFS_TIMER_VALUE  = 6'h05;
    localparam logic [5:0] OFS_TIMER_STATUS = 6'h06;

    typedef enum logic {T_IDLE = 1'b0, T_RUN = 1'b1} tstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]         ram_idx;
    logic                  mmio_sel;
    logic [5:0]            mmio_word;
    logic                  wr_mmio, wr_gpio, wr_load, wr_ctrl, wr_status;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    logic [GPIO_WIDTH-1:0] gpio_sync_p1, gpio_sync_p2;
    logic [DATA_WIDTH-1:0] cycle_cnt;
    logic [DATA_WIDTH-1:0] timer_load, timer_value;
    tstate_t               tstate;
    logic                  timer_auto, timer_irq_en, expired;
    logic                  timer_expiry;
    logic                  unused_addr_bits;

    assign mmio_sel  = (memaddr[31:16] == 16'hFFFF);
    assign mmio_word = memaddr[7:2];
    assign ram_idx   = memaddr[AW+1:2];
    assign unused_addr_bits = ^memaddr;

    assign wr_mmio   = memwrite && mmio_sel;
    assign wr_gpio   = wr_mmio && (mmio_word == OFS_GPIO_OUT);
    assign wr_load   = wr_mmio && (mmio_word == OFS_TIMER_LOAD);
    assign wr_ctrl   = wr_mmio && (mmio_word == OFS_TIMER_CTRL);
    assign wr_status = wr_mmio && (mmio_word == OFS_TIMER_STATUS);

    assign timer_expiry = (tstate == T_RUN) && (timer_value == '0);

    always_ff @(posedge clk) begin
        if (memwrite && !mmio_sel)
            mem[ram_idx] <= writedata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out     <= '0;
            gpio_sync_p1 <= '0;
            gpio_sync_p2 <= '0;
            cycle_cnt    <= '0;
        end else begin
            if (wr_gpio)
                gpio_out <= writedata[GPIO_WIDTH-1:0];
            gpio_sync_p1 <= gpio_in;
            gpio_sync_p2 <= gpio_sync_p1;
            cycle_cnt    <= cycle_cnt + ONE;
        end
    end

    // Hardware updates first; software writes later in the block take priority,
    // except that an expiry always wins over a write-1-clear of the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstate       <= T_IDLE;
            timer_auto   <= 1'b0;
            timer_irq_en <= 1'b0;
            timer_load   <= '0;
            timer_value  <= '0;
            expired      <= 1'b0;
            timer_irq    <= 1'b0;
        end else begin
            case (tstate)
                T_RUN: begin
                    if (timer_value != '0)
                        timer_value <= timer_value - ONE;
                    else if (timer_auto)
                        timer_value <= timer_load;
                    else
                        tstate <= T_IDLE;
                end
                T_IDLE: ;
            endcase
            if (wr_load) begin
                timer_load  <= writedata;
                timer_value <= writedata;
            end
            if (wr_ctrl) begin
                tstate       <= writedata[0] ? T_RUN : T_IDLE;
                timer_auto   <= writedata[1];
                timer_irq_en <= writedata[2];
            end
            if (timer_expiry)
                expired <= 1'b1;
            else if (wr_status && writedata[0])
                expired <= 1'b0;
            timer_irq <= expired && timer_irq_en;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_word)
            OFS_GPIO_OUT:     mmio_rdata = DATA_WIDTH'(gpio_out);
            OFS_GPIO_IN:      mmio_rdata = DATA_WIDTH'(gpio_sync_p2);
            OFS_CYCLE_CNT:    mmio_rdata = cycle_cnt;
            OFS_TIMER_LOAD:   mmio_rdata = timer_load;
            OFS_TIMER_CTRL:   mmio_rdata = DATA_WIDTH'({timer_irq_en, timer_auto, tstate == T_RUN});
            OFS_TIMER_VALUE:  mmio_rdata = timer_value;
            OFS_TIMER_STATUS: mmio_rdata = DATA_WIDTH'(expired);
            default:          mmio_rdata = '0;
        endcase
    end

    assign readdata = mmio_sel ? mmio_rdata : mem[ram_idx];

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Scoreboard bench for mips_dmem_mmio: expected load data is queued when the
// access is issued and compared when readdata is sampled.
module tb_mips_dmem_mmio;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cyc_model;

    localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE    = 32'hFFFF_0008;
    localparam logic [31:0] A_LOAD     = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL     = 32'hFFFF_0010;
    localparam logic [31:0] A_VALUE    = 32'hFFFF_0014;
    localparam logic [31:0] A_STATUS   = 32'hFFFF_0018;

    mips_dmem_mmio #(.DATA_WIDTH(32), .MEM_DEPTH(256), .GPIO_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memaddr(memaddr),
        .writedata(writedata), .readdata(readdata), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count: cleared by reset, +1 per rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_model <= '0;
        else        cyc_model <= cyc_model + 32'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1;
        memaddr = a;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        memaddr = a;
        #1;
        v = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gpio_out !== 16'h0 || timer_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gpio_out=%h timer_irq=%b, expected 0000/0", gpio_out, timer_irq);
        end
        rst_n = 1'b1;
        exp_q.push_back(32'd0);
        rd(A_CYCLE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_cycle_first: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_timer_value: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_timer_ctrl: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_status: got %h expected %h", got, exp); end
    endtask

    task automatic test_ram();
        logic [31:0] got, exp;
        bus_write(32'h40, 32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        rd(32'h40, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_load: got %h expected %h", got, exp); end
        exp_q.push_back(32'h1234_5678);
        rd(32'h440, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_alias: got %h expected %h", got, exp); end
        // store and load the same word in one cycle: old data first, new data after the edge
        memwrite = 1'b1; writedata = 32'hDEAD_BEEF;
        exp_q.push_back(32'h1234_5678);
        rd(32'h43, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_same_cycle: got %h expected %h", got, exp); end
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        memwrite = 1'b0;
        rd(32'h40, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_next_cycle: got %h expected %h", got, exp); end
        bus_write(32'h84, 32'h0BAD_F00D);
        exp_q.push_back(32'h0BAD_F00D);
        rd(32'h84, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_second_word: got %h expected %h", got, exp); end
    endtask

    task automatic test_gpio();
        logic [31:0] got, exp;
        bus_write(A_GPIO_OUT, 32'hFFFF_A5A5);
        checks++;
        if (gpio_out !== 16'hA5A5) begin errors++; $display("FAIL gpio_out_pin: got %h expected a5a5", gpio_out); end
        exp_q.push_back(32'h0000_A5A5);
        rd(A_GPIO_OUT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL gpio_out_read: got %h expected %h", got, exp); end
        gpio_in = 16'h00F0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_00F0);
        for (int e = 0; e < 3; e++) begin
            if (e > 0) tick();
            rd(A_GPIO_IN, got); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL gpio_in_sync_edge%0d: got %h expected %h", e, got, exp); end
        end
        bus_write(32'hFFFF_0020, 32'hFFFF_FFFF);
        bus_write(A_GPIO_IN, 32'h0000_1234);
        bus_write(32'hFFFF_0040, 32'h5555_5555);
        exp_q.push_back(32'h0);
        rd(32'hFFFF_0020, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mmio_unmapped: got %h expected %h", got, exp); end
        exp_q.push_back(32'h0000_00F0);
        rd(A_GPIO_IN, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL gpio_in_ro: got %h expected %h", got, exp); end
        exp_q.push_back(32'hDEAD_BEEF);
        rd(32'h40, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mmio_no_ram_write: got %h expected %h", got, exp); end
    endtask

    task automatic test_cycle_cnt();
        logic [31:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(cyc_model);
            rd(A_CYCLE, got); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL cycle_cnt_%0d: got %h expected %h", i, got, exp); end
            tick();
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] got, exp;
        bus_write(A_LOAD, 32'd5);
        bus_write(A_CTRL, 32'b101);
        exp_q.push_back(32'd5);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oneshot_start: got %h expected %h", got, exp); end
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(32'(5 - k));
            tick();
            rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL oneshot_count_%0d: got %h expected %h", k, got, exp); end
        end
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oneshot_not_yet_expired: got %h expected %h", got, exp); end
        tick();
        exp_q.push_back(32'd1);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oneshot_expired: got %h expected %h", got, exp); end
        exp_q.push_back(32'b100);
        rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oneshot_enable_clear: got %h expected %h", got, exp); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_early: got %b expected 0", timer_irq); end
        tick();
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b expected 1", timer_irq); end
        exp_q.push_back(32'd0);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oneshot_hold_zero: got %h expected %h", got, exp); end
        bus_write(A_STATUS, 32'd1);
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL status_w1c: got %h expected %h", got, exp); end
        tick();
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", timer_irq); end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_autoreload();
        logic [31:0] got, exp;
        bus_write(A_LOAD, 32'd3);
        bus_write(A_CTRL, 32'b011);
        repeat (3) tick();
        exp_q.push_back(32'd0);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_reach_zero: got %h expected %h", got, exp); end
        tick();
        exp_q.push_back(32'd3);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_reload: got %h expected %h", got, exp); end
        exp_q.push_back(32'd1);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_expired_1: got %h expected %h", got, exp); end
        bus_write(A_STATUS, 32'd1);
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_cleared: got %h expected %h", got, exp); end
        repeat (2) tick();
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_period_early: got %h expected %h", got, exp); end
        // this clear lands on the next expiry edge, so the flag must stay set
        bus_write(A_STATUS, 32'd1);
        exp_q.push_back(32'd1);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_set_beats_clear: got %h expected %h", got, exp); end
        exp_q.push_back(32'd3);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL auto_reload_2: got %h expected %h", got, exp); end
        bus_write(A_LOAD, 32'd10);
        exp_q.push_back(32'd10);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL load_beats_decrement: got %h expected %h", got, exp); end
        tick();
        exp_q.push_back(32'd9);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL load_then_count: got %h expected %h", got, exp); end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL auto_irq_masked: got %b expected 0", timer_irq); end
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STATUS, 32'd1);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] got, exp;
        bus_write(32'h80, 32'hCAFE_F00D);
        bus_write(A_LOAD, 32'd1);
        bus_write(A_CTRL, 32'b111);
        repeat (3) tick();
        checks++;
        if (timer_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", timer_irq); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (timer_irq !== 1'b0 || gpio_out !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: irq=%b gpio_out=%h expected 0/0000", timer_irq, gpio_out);
        end
        exp_q.push_back(32'd0);
        rd(A_CYCLE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_cycle: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_VALUE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_value: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_ctrl: got %h expected %h", got, exp); end
        exp_q.push_back(32'd0);
        rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL async_reset_status: got %h expected %h", got, exp); end
        tick();
        exp_q.push_back(32'hCAFE_F00D);
        rd(32'h80, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_survives_reset: got %h expected %h", got, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_q.push_back(cyc_model);
        rd(A_CYCLE, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL cycle_after_reset: got %h expected %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_cycle_cnt();
        test_oneshot();
        test_autoreload();
        test_reset_midcount();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "timeout");
    end

endmodule
